// File: rtl/host_rdback.sv
// Purpose: host read-back; Wishbone-reads LEN words from ADDR upward, streams each word LSB byte first.
// Latency: start->first stb 1 cycle, ack->first tx_valid 1 cycle, last byte accept->done 1 cycle.
// Backpressure: tx_valid_o/tx_data_o held stable until tx_ready_i; no bus cycle while a word drains.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   start_i, addr_i, len_i           burst request (sampled only in IDLE)
//   busy_o, done_o, err_o            burst status; done_o/err_o are 1-cycle pulses
//   wb_*                             classic single-read Wishbone master
//   tx_data_o, tx_valid_o, tx_ready_i  byte stream to the host link
module host_rdback #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wb_adr_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      adr;
  logic [LEN_W-1:0] words;
  logic [31:0]      word;
  logic [1:0]       idx;
  logic [TW-1:0]    tcnt;
  logic             abort;
  logic             timed_out;

  // tcnt counts completed no-response cycles, so the strobe stays up for
  // exactly TIMEOUT cycles before giving up. TIMEOUT==0 never times out.
  assign timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

  assign wb_we_o  = 1'b0;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    state_nxt  = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    wb_adr_o   = 32'h0;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_sel_o   = 4'h0;
    tx_data_o  = 8'h0;
    tx_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = (len_i == '0) ? DONE : RD;
      end
      RD: begin
        busy_o   = 1'b1;
        wb_adr_o = adr;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'hF;
        // error wins over ack; ack wins over a coincident timeout
        if (wb_err_i)      state_nxt = DONE;
        else if (wb_ack_i) state_nxt = SEND;
        else if (timed_out) state_nxt = DONE;
      end
      SEND: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_data_o  = word[{idx, 3'b000} +: 8];
        if (tx_ready_i && idx == 2'd3)
          state_nxt = (words <= LEN_W'(1)) ? DONE : RD;
      end
      DONE: begin
        done_o    = 1'b1;
        err_o     = abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr   <= 32'h0;
      words <= '0;
      word  <= 32'h0;
      idx   <= 2'd0;
      tcnt  <= '0;
      abort <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            adr   <= {addr_i[31:2], 2'b00};
            words <= len_i;
            idx   <= 2'd0;
            tcnt  <= '0;
            abort <= 1'b0;
          end
        end
        RD: begin
          if (wb_err_i) begin
            abort <= 1'b1;
          end else if (wb_ack_i) begin
            word <= wb_dat_i;
            idx  <= 2'd0;
            tcnt <= '0;
          end else if (timed_out) begin
            abort <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              adr <= adr + 32'd4;
              if (words != '0) words <= words - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_rdback.sv
module tb_host_rdback;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i;

  host_rdback #(.LEN_W(16), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ga[$];
  logic [7:0]  gb[$];

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          dly;
    int          err_word;
    bit          noack;
    int          mode;
    bit          exp_err;
    int          exp_bytes;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave memory contents: fixed word at 0x100, hash elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h100) return 32'h11223344;
    return (a * 32'h9E3779B1) + 32'h5A5A0F0F;
  endfunction

  function automatic logic [55:0] all_outs();
    return {busy_o, done_o, err_o, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o,
            wb_sel_o, wb_cti_o, wb_bte_o, tx_data_o, tx_valid_o};
  endfunction

  // mode: 0 always ready, 1 ready low for 5 valid cycles after first byte, 2 random
  task automatic run_burst(input string nm, input logic [31:0] addr, input int len,
                           input int dly, input int err_word, input bit noack,
                           input int mode, input bit exp_err, input int exp_bytes);
    logic [31:0] ea[$];
    logic [7:0]  eb[$];
    logic [31:0] a, w, cur_adr;
    logic [7:0]  prev_dat;
    bit aborted, got_done, got_err, prev_stb, prev_vld, prev_acc, r;
    int nw, stb_cnt, n_stb, ack_cyc, last_acc, vcnt, lat_bad, stab_bad, ovl_bad, bad;

    // reference: which words get read, which bytes come out
    aborted = (len > 0) && (noack || (err_word >= 0 && err_word < len));
    nw = len;
    if (len > 0 && noack) nw = 1;
    else if (err_word >= 0 && err_word < len) nw = err_word + 1;
    for (int i = 0; i < nw; i++) begin
      a = {addr[31:2], 2'b00} + 32'(4 * i);
      ea.push_back(a);
      if (!(aborted && i == nw - 1)) begin
        w = mem(a);
        for (int b = 0; b < 4; b++) eb.push_back(8'(w >> (8 * b)));
      end
    end

    ga.delete(); gb.delete();
    got_done = 0; got_err = 0; prev_stb = 0; prev_vld = 0; prev_acc = 0; prev_dat = 8'h0;
    stb_cnt = 0; n_stb = 0; ack_cyc = -10; last_acc = -10; vcnt = 0;
    lat_bad = 0; stab_bad = 0; ovl_bad = 0; cur_adr = 32'h0;

    @(negedge clk);
    start_i = 1'b1; addr_i = addr; len_i = len[15:0];
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (done_o) begin
        got_done = 1; got_err = err_o;
        if (busy_o) lat_bad++;
        if (len > 0 && !err_o && last_acc != c - 1) lat_bad++;
        if (len == 0 && c != 1) lat_bad++;
        // start while in DONE must be ignored
        start_i = (mode == 2);
        break;
      end
      if (c == 1 && len > 0 && !wb_stb_o) lat_bad++;
      start_i = (mode == 2) && ($urandom_range(0, 5) == 0);
      addr_i = $urandom; len_i = 16'($urandom);
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (wb_stb_o) begin
        n_stb++;
        if (!prev_stb) begin
          ga.push_back(wb_adr_o); stb_cnt = 0; cur_adr = wb_adr_o;
        end else if (wb_adr_o !== cur_adr) stab_bad++;
        if (!wb_cyc_o || wb_sel_o !== 4'hF) stab_bad++;
        if (tx_valid_o) ovl_bad++;
        if (!noack && stb_cnt == dly) begin
          if (ga.size() - 1 == err_word) wb_err_i = 1'b1;
          else begin
            wb_ack_i = 1'b1; wb_dat_i = mem(wb_adr_o); ack_cyc = c;
          end
        end
        stb_cnt++;
      end
      prev_stb = wb_stb_o;
      tx_ready_i = 1'b0;
      if (tx_valid_o) begin
        if (!prev_vld && gb.size() % 4 == 0 && c != ack_cyc + 1) lat_bad++;
        if (prev_vld && !prev_acc && tx_data_o !== prev_dat) stab_bad++;
        case (mode)
          0:       r = 1;
          1:       r = !(vcnt >= 1 && vcnt <= 5);
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        vcnt++;
        tx_ready_i = r;
        if (r) begin gb.push_back(tx_data_o); last_acc = c; end
        prev_acc = r; prev_dat = tx_data_o;
      end else prev_acc = 0;
      prev_vld = tx_valid_o;
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; tx_ready_i = 1'b0;

    chk({nm, " done seen"}, 64'(got_done), 64'(1));
    chk({nm, " err"}, 64'(got_err), 64'(exp_err));
    chk({nm, " byte count"}, 64'(gb.size()), 64'(exp_bytes));
    bad = (gb.size() != eb.size()) ? 1 : 0;
    for (int i = 0; i < gb.size() && i < eb.size(); i++) if (gb[i] !== eb[i]) bad++;
    chk({nm, " byte content errors"}, 64'(bad), 64'(0));
    bad = (ga.size() != ea.size()) ? 1 : 0;
    for (int i = 0; i < ga.size() && i < ea.size(); i++) if (ga[i] !== ea[i]) bad++;
    chk({nm, " address errors"}, 64'(bad), 64'(0));
    chk({nm, " latency errors"}, 64'(lat_bad), 64'(0));
    chk({nm, " stability errors"}, 64'(stab_bad), 64'(0));
    chk({nm, " bus/tx overlap"}, 64'(ovl_bad), 64'(0));
    if (noack) chk({nm, " stb cycles before timeout"}, 64'(n_stb), 64'(TO));
    if (len == 0) chk({nm, " stb cycles"}, 64'(n_stb), 64'(0));

    @(negedge clk);
    start_i = 1'b0;
    chk({nm, " done pulse width"}, 64'({busy_o, done_o, err_o}), 64'(0));
    @(negedge clk);
    chk({nm, " idle after"}, 64'({busy_o, wb_stb_o, tx_valid_o}), 64'(0));
  endtask

  initial begin
    bit          seen;
    logic [31:0] ra;
    int          rl, rd, re;
    bit          rerr;

    tbl[0] = '{32'h0000_0100, 1, 2, -1, 0, 0, 0, 4};
    tbl[1] = '{32'hFFFF_FFF8, 3, 0, -1, 0, 0, 0, 12};
    tbl[2] = '{32'h0000_0203, 2, 1, -1, 0, 1, 0, 8};
    tbl[3] = '{32'h0000_0400, 3, 1, 1, 0, 0, 1, 4};
    tbl[4] = '{32'h0000_0500, 2, 0, -1, 1, 0, 1, 0};
    tbl[5] = '{32'h0000_0600, 0, 0, -1, 0, 0, 0, 0};
    tbl[6] = '{32'h0000_1000, 3, 3, 2, 0, 2, 1, 8};

    rst_ni = 1'b0; start_i = 1'b0; addr_i = 32'h0; len_i = 16'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; tx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'(all_outs()), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle outputs", 64'(all_outs()), 64'(0));

    for (int i = 0; i < 7; i++) begin
      run_burst($sformatf("vec%0d", i), tbl[i].addr, tbl[i].len, tbl[i].dly,
                tbl[i].err_word, tbl[i].noack, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_bytes);
      if (i == 0) begin
        if (gb.size() == 4) chk("vec0 bytes 44,33,22,11", 64'({gb[0], gb[1], gb[2], gb[3]}), 64'(32'h44332211));
        else chk("vec0 byte count", 64'(gb.size()), 64'(4));
      end
      if (i == 1) begin
        if (ga.size() == 3) chk("vec1 wrapped address", 64'(ga[2]), 64'(0));
        else chk("vec1 address count", 64'(ga.size()), 64'(3));
      end
    end

    // reset while a word is draining
    @(negedge clk);
    start_i = 1'b1; addr_i = 32'h700; len_i = 16'd2;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      wb_ack_i = wb_stb_o; wb_dat_i = mem(wb_adr_o);
      if (tx_valid_o) begin seen = 1; break; end
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    chk("reset-test reached SEND", 64'(seen), 64'(1));
    tx_ready_i = 1'b1;
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("async reset mid-SEND outputs", 64'(all_outs()), 64'(0));
    tx_ready_i = 1'b0;
    @(negedge clk);
    chk("held reset outputs", 64'(all_outs()), 64'(0));
    rst_ni = 1'b1;
    run_burst("post-reset", 32'h800, 2, 1, -1, 0, 0, 0, 8);

    // randomized bursts against the reference model
    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rl = $urandom_range(1, 4);
      rd = $urandom_range(0, 4);
      re = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rl - 1) : -1;
      rerr = (re >= 0);
      run_burst($sformatf("rand%0d", k), ra, rl, rd, re, 0, 2, rerr, 4 * (rerr ? re : rl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
